// File: rtl/pipeline_ctrl.sv
// Boot, hazard and drain sequencer for the 3-stage IF_ID / EX_MEM / WB core.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
//
// state | meaning
// IDLE  | all units held in reset, waiting for start
// BOOT  | unit resets held for BOOT_CYCLES cycles
// LOAD  | one-cycle memory-image load strobe
// RUN   | normal execution; branch squash and load-use bubble handling
// STALL | extra load-use bubbles beyond the first (LOAD_LAT > 1)
// DRAIN | two cycles flushing the pipe after halt
// HALT  | pipe frozen, contents visible, waiting for start
module pipeline_ctrl #(
   parameter int BOOT_CYCLES = 4,
   parameter int LOAD_LAT    = 1
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        start,
   input  logic        halt,
   input  logic [3:0]  ifid_RA,
   input  logic [3:0]  ifid_RB,
   input  logic        ifid_uses_RB,
   input  logic [3:0]  ex_WC,
   input  logic        ex_is_load,
   input  logic        ex_W_RB,
   input  logic        branch_taken,
   output logic        pc_RESET,
   output logic        im_RESET,
   output logic        rb_RESET,
   output logic        tf_RESET,
   output logic        dm_RESET,
   output logic        pc_ENABLE,
   output logic        im_read_file,
   output logic        dm_read_file,
   output logic        reg_ifid_exmem_RESET,
   output logic        reg_ifid_exmem_ENABLE,
   output logic        reg_exmem_wb_RESET,
   output logic        reg_exmem_wb_ENABLE,
   output logic [2:0]  state,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_BOOT  = 3'd1,
      S_LOAD  = 3'd2,
      S_RUN   = 3'd3,
      S_STALL = 3'd4,
      S_DRAIN = 3'd5,
      S_HALT  = 3'd6
   } state_t;

   localparam logic [15:0] BOOT_LD      = 16'(BOOT_CYCLES - 1);
   localparam bit          MULTI_BUBBLE = (LOAD_LAT > 1);
   // The RUN-state hazard cycle is the first bubble, so STALL covers LOAD_LAT-1.
   localparam logic [15:0] STALL_LD     = MULTI_BUBBLE ? 16'(LOAD_LAT - 2) : 16'd0;
   localparam logic [15:0] DRAIN_LD     = 16'd1;

   state_t      st;
   logic [15:0] timer;
   logic        hazard;
   logic        boot_entry;

   assign state      = st;
   assign hazard     = ex_is_load & ex_W_RB &
                       ((ex_WC == ifid_RA) | (ifid_uses_RB & (ex_WC == ifid_RB)));
   assign boot_entry = ((st == S_IDLE) | (st == S_HALT)) & start;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         st    <= S_IDLE;
         timer <= 16'd0;
      end else begin
         case (st)
            S_IDLE: begin
               if (start) begin
                  st    <= S_BOOT;
                  timer <= BOOT_LD;
               end
            end
            S_BOOT: begin
               if (timer == 16'd0) st <= S_LOAD;
               else                timer <= timer - 16'd1;
            end
            S_LOAD: st <= S_RUN;
            S_RUN: begin
               if (branch_taken) begin
                  st <= S_RUN;
               end else if (hazard) begin
                  if (MULTI_BUBBLE) begin
                     st    <= S_STALL;
                     timer <= STALL_LD;
                  end
               end else if (halt) begin
                  st    <= S_DRAIN;
                  timer <= DRAIN_LD;
               end
            end
            S_STALL: begin
               if (timer == 16'd0) st <= S_RUN;
               else                timer <= timer - 16'd1;
            end
            S_DRAIN: begin
               if (timer == 16'd0) st <= S_HALT;
               else                timer <= timer - 16'd1;
            end
            S_HALT: begin
               if (start) begin
                  st    <= S_BOOT;
                  timer <= BOOT_LD;
               end
            end
            default: st <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      pc_RESET              = 1'b0;
      im_RESET              = 1'b0;
      rb_RESET              = 1'b0;
      tf_RESET              = 1'b0;
      dm_RESET              = 1'b0;
      pc_ENABLE             = 1'b0;
      im_read_file          = 1'b0;
      dm_read_file          = 1'b0;
      reg_ifid_exmem_RESET  = 1'b0;
      reg_ifid_exmem_ENABLE = 1'b0;
      reg_exmem_wb_RESET    = 1'b0;
      reg_exmem_wb_ENABLE   = 1'b0;
      case (st)
         S_IDLE, S_BOOT: begin
            pc_RESET             = 1'b1;
            im_RESET             = 1'b1;
            rb_RESET             = 1'b1;
            tf_RESET             = 1'b1;
            dm_RESET             = 1'b1;
            reg_ifid_exmem_RESET = 1'b1;
            reg_exmem_wb_RESET   = 1'b1;
         end
         S_LOAD: begin
            im_read_file = 1'b1;
            dm_read_file = 1'b1;
         end
         S_RUN: begin
            pc_ENABLE             = 1'b1;
            reg_ifid_exmem_ENABLE = 1'b1;
            reg_exmem_wb_ENABLE   = 1'b1;
            if (branch_taken) begin
               reg_ifid_exmem_RESET = 1'b1;
            end else if (hazard) begin
               pc_ENABLE            = 1'b0;
               reg_ifid_exmem_RESET = 1'b1;
            end else if (halt) begin
               pc_ENABLE = 1'b0;
            end
         end
         S_STALL, S_DRAIN: begin
            reg_ifid_exmem_RESET  = 1'b1;
            reg_ifid_exmem_ENABLE = 1'b1;
            reg_exmem_wb_ENABLE   = 1'b1;
         end
         default: ;
      endcase
   end

`ifdef PIPE_CTRL_PERF_EN
   logic stall_inc;
   logic flush_inc;

   assign stall_inc = ((st == S_RUN) & ~branch_taken & hazard) | (st == S_STALL);
   assign flush_inc = (st == S_RUN) & branch_taken;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         stall_cnt <= 16'd0;
         flush_cnt <= 16'd0;
      end else if (boot_entry) begin
         stall_cnt <= 16'd0;
         flush_cnt <= 16'd0;
      end else begin
         if (stall_inc && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
         if (flush_inc && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
      end
   end
`else
   assign stall_cnt = 16'h0000;
   assign flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: instance 0 uses LOAD_LAT=1, instance 1 uses LOAD_LAT=3.
module tb_pipeline_ctrl;

`ifdef PIPE_CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic       CLK = 1'b0;
   logic       RESET;
   logic       start, halt, ifid_uses_RB, ex_is_load, ex_W_RB, branch_taken;
   logic [3:0] ifid_RA, ifid_RB, ex_WC;

   logic [1:0]  pc_rst, im_rst, rb_rst, tf_rst, dm_rst, pc_en, im_rd, dm_rd;
   logic [1:0]  r1_rst, r1_en, r2_rst, r2_en;
   logic [2:0]  st   [2];
   logic [15:0] scnt [2];
   logic [15:0] fcnt [2];
   logic [6:0]  rv   [2];

   int n_vec = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      pipeline_ctrl #(.BOOT_CYCLES(4), .LOAD_LAT(g == 0 ? 1 : 3)) u_dut (
         .CLK                   (CLK),
         .RESET                 (RESET),
         .start                 (start),
         .halt                  (halt),
         .ifid_RA               (ifid_RA),
         .ifid_RB               (ifid_RB),
         .ifid_uses_RB          (ifid_uses_RB),
         .ex_WC                 (ex_WC),
         .ex_is_load            (ex_is_load),
         .ex_W_RB               (ex_W_RB),
         .branch_taken          (branch_taken),
         .pc_RESET              (pc_rst[g]),
         .im_RESET              (im_rst[g]),
         .rb_RESET              (rb_rst[g]),
         .tf_RESET              (tf_rst[g]),
         .dm_RESET              (dm_rst[g]),
         .pc_ENABLE             (pc_en[g]),
         .im_read_file          (im_rd[g]),
         .dm_read_file          (dm_rd[g]),
         .reg_ifid_exmem_RESET  (r1_rst[g]),
         .reg_ifid_exmem_ENABLE (r1_en[g]),
         .reg_exmem_wb_RESET    (r2_rst[g]),
         .reg_exmem_wb_ENABLE   (r2_en[g]),
         .state                 (st[g]),
         .stall_cnt             (scnt[g]),
         .flush_cnt             (fcnt[g])
      );
      assign rv[g] = {pc_rst[g], im_rst[g], rb_rst[g], tf_rst[g], dm_rst[g], r1_rst[g], r2_rst[g]};
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] cnt_exp(input logic [31:0] v);
      return PERF ? v : 32'd0;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   task automatic clr_hazard();
      ex_is_load   = 1'b0;
      ex_W_RB      = 1'b0;
      ex_WC        = 4'd0;
      ifid_RA      = 4'd0;
      ifid_RB      = 4'd0;
      ifid_uses_RB = 1'b0;
   endtask

   task automatic set_hazard();
      ex_is_load = 1'b1;
      ex_W_RB    = 1'b1;
      ex_WC      = 4'd5;
      ifid_RA    = 4'd5;
   endtask

   initial begin
      RESET = 1'b1; start = 1'b0; halt = 1'b0; branch_taken = 1'b0;
      clr_hazard();
      #3;
      // T1: reset state, boot, load, run
      for (int i = 0; i < 2; i++) begin
         chk("rst_state", 32'(st[i]), 32'd0);
         chk("rst_resets", 32'(rv[i]), 32'h7F);
         chk("rst_scnt", 32'(scnt[i]), 32'd0);
      end
      chk("rst_pc_en", 32'(pc_en), 32'd0);
      tick();
      RESET = 1'b0;
      start = 1'b1;
      #1;
      chk("idle_state", 32'(st[0]), 32'd0);
      tick();
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("boot_state", 32'(st[0]), 32'd1);
         chk("boot_resets", 32'({rv[0], rv[1]}), 32'h3FFF);
         chk("boot_pc_en", 32'(pc_en), 32'd0);
         tick();
      end
      chk("load_state", 32'(st[1]), 32'd2);
      chk("load_strobes", 32'({im_rd, dm_rd}), 32'hF);
      chk("load_resets", 32'({rv[0], rv[1]}), 32'h0);
      chk("load_en", 32'({r1_en, r2_en}), 32'h0);
      tick();
      chk("run_state", 32'({st[0], st[1]}), 32'o33);
      chk("run_en", 32'({pc_en, r1_en, r2_en}), 32'h3F);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("run_start_ignored", 32'({st[0], st[1]}), 32'o33);

      // hazard term probes, combinational only
      ex_is_load = 1'b1; ex_W_RB = 1'b1; ex_WC = 4'd7; ifid_RA = 4'd2; ifid_RB = 4'd7;
      #1 chk("rb_unused_no_haz", 32'(pc_en), 32'h3);
      ifid_uses_RB = 1'b1;
      #1 chk("rb_haz_pc", 32'(pc_en), 32'h0);
      chk("rb_haz_bubble", 32'(r1_rst), 32'h3);
      ex_W_RB = 1'b0;
      #1 chk("no_wrb_no_haz", 32'(pc_en), 32'h3);
      clr_hazard();
      #1;

      // T2: load-use hazard, 1 and 3 bubbles
      set_hazard();
      #1 chk("haz_pc_en", 32'(pc_en), 32'h0);
      chk("haz_bubble", 32'(r1_rst), 32'h3);
      tick();
      clr_hazard();
      #1 chk("haz1_states", 32'({st[0], st[1]}), 32'o34);
      chk("haz1_scnt0", 32'(scnt[0]), cnt_exp(1));
      chk("haz1_scnt1", 32'(scnt[1]), cnt_exp(1));
      chk("stall_pc_en", 32'(pc_en), 32'h1);
      chk("stall_bubble", 32'(r1_rst[1]), 32'h1);
      tick();
      chk("haz2_state1", 32'(st[1]), 32'd4);
      chk("haz2_scnt1", 32'(scnt[1]), cnt_exp(2));
      tick();
      chk("haz3_state1", 32'(st[1]), 32'd3);
      chk("haz3_scnt1", 32'(scnt[1]), cnt_exp(3));
      chk("haz3_scnt0", 32'(scnt[0]), cnt_exp(1));

      // T3: branch beats hazard
      set_hazard();
      branch_taken = 1'b1;
      #1 chk("br_pc_en", 32'(pc_en), 32'h3);
      chk("br_squash", 32'(r1_rst), 32'h3);
      tick();
      clr_hazard();
      branch_taken = 1'b0;
      #1 chk("br_states", 32'({st[0], st[1]}), 32'o33);
      chk("br_fcnt0", 32'(fcnt[0]), cnt_exp(1));
      chk("br_fcnt1", 32'(fcnt[1]), cnt_exp(1));
      chk("br_scnt", 32'({scnt[0], scnt[1]}), {cnt_exp(1)[15:0], cnt_exp(3)[15:0]});

      // T4: halt, drain, restart
      halt = 1'b1;
      #1 chk("halt_pc_en", 32'(pc_en), 32'h0);
      chk("halt_no_bubble", 32'(r1_rst), 32'h0);
      tick();
      #1 chk("drain1_state", 32'({st[0], st[1]}), 32'o55);
      chk("drain1_ctl", 32'({pc_en, r1_rst, r1_en, r2_en}), 32'h3F);
      tick();
      halt = 1'b0;
      chk("drain2_state", 32'({st[0], st[1]}), 32'o55);
      tick();
      chk("halt_state", 32'({st[0], st[1]}), 32'o66);
      chk("halt_en", 32'({pc_en, r1_en, r2_en}), 32'h0);
      chk("halt_resets", 32'({rv[0], rv[1]}), 32'h0);
      chk("halt_fcnt", 32'(fcnt[0]), cnt_exp(1));
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("restart_state", 32'({st[0], st[1]}), 32'o11);
      chk("restart_resets", 32'(rv[0]), 32'h7F);
      chk("restart_cnt_clr", 32'({scnt[1], fcnt[1]}), 32'h0);
      repeat (5) tick();
      chk("rerun_state", 32'({st[0], st[1]}), 32'o33);

      // T5: async reset in the middle of STALL
      set_hazard();
      tick();
      clr_hazard();
      #1 chk("pre_rst_stall", 32'(st[1]), 32'd4);
      #2 RESET = 1'b1;
      #1 chk("async_state", 32'({st[0], st[1]}), 32'o00);
      chk("async_resets", 32'({rv[0], rv[1]}), 32'h3FFF);
      chk("async_cnt", 32'({scnt[0], scnt[1]}), 32'h0);
      tick();
      RESET = 1'b0;

`ifdef PIPE_CTRL_PERF_EN
      // T6: stall counter saturation
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      set_hazard();
      repeat (65534) tick();
      chk("sat_edge0", 32'(scnt[0]), 32'hFFFE);
      repeat (6) tick();
      chk("sat_scnt0", 32'(scnt[0]), 32'hFFFF);
      chk("sat_scnt1", 32'(scnt[1]), 32'hFFFF);
      clr_hazard();
`else
      chk("off_scnt", 32'({scnt[0], scnt[1]}), 32'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
